// File: rtl/draw_pkg.sv
// Shared widths, sprite attribute record and update-FSM states for the
// sprite drawing layer of the VGA pixel pipeline.
package draw_pkg;

   localparam int VGA_RGB_W = 12;
   localparam int VGA_CNT_W = 11;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic        hflip;
      logic        vflip;
      logic        en;
   } sprite_attr_t;

   typedef enum logic {
      UPD_IDLE,
      UPD_PENDING
   } upd_state_t;

endpackage

// File: rtl/vga_if.sv
// VGA pixel-stream bundle passed between drawing layers.
interface vga_if;
   import draw_pkg::*;

   logic [VGA_CNT_W-1:0] hcount;
   logic [VGA_CNT_W-1:0] vcount;
   logic                 hsync;
   logic                 vsync;
   logic                 hblnk;
   logic                 vblnk;
   logic [VGA_RGB_W-1:0] rgb;

   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_delay.sv
// Fixed-depth register delay line for the VGA timing fields, so they stay
// aligned with the colour path of a drawing layer.
module vga_delay
   import draw_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [VGA_CNT_W-1:0] hcount_i,
   input  logic [VGA_CNT_W-1:0] vcount_i,
   input  logic                 hsync_i,
   input  logic                 vsync_i,
   input  logic                 hblnk_i,
   input  logic                 vblnk_i,
   output logic [VGA_CNT_W-1:0] hcount_o,
   output logic [VGA_CNT_W-1:0] vcount_o,
   output logic                 hsync_o,
   output logic                 vsync_o,
   output logic                 hblnk_o,
   output logic                 vblnk_o
);

   localparam int TW = 2 * VGA_CNT_W + 4;

   logic [TW-1:0] pipe_q [DEPTH];

   // All timing fields travel as one packed word down the shift chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= {hcount_i, vcount_i, hsync_i, vsync_i, hblnk_i, vblnk_i};
         for (int i = 1; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign {hcount_o, vcount_o, hsync_o, vsync_o, hblnk_o, vblnk_o} = pipe_q[DEPTH-1];

endmodule

// File: rtl/draw_sprite_ctl.sv
// Overlays one W x H ROM bitmap onto the VGA stream with mirroring, enable and
// frame-synchronous attribute updates. DRAW_SPRITE_CTL_TRANSP_EN adds a colour key.
module draw_sprite_ctl
   import draw_pkg::*;
#(
   parameter int W       = 48,
   parameter int H       = 64,
   parameter int AX_W    = 6,
   parameter int AY_W    = 6,
   parameter int ROM_LAT = 1
`ifdef DRAW_SPRITE_CTL_TRANSP_EN
   ,
   parameter logic [VGA_RGB_W-1:0] TRANSP_KEY = 12'hF0F
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   upd_valid,
   output logic                   upd_ready,
   input  logic [11:0]            upd_x,
   input  logic [11:0]            upd_y,
   input  logic                   upd_hflip,
   input  logic                   upd_vflip,
   input  logic                   upd_en,
   input  logic [VGA_RGB_W-1:0]   rgb_pixel,
   output logic [AY_W+AX_W-1:0]   pixel_addr,
   vga_if.in                      vga_in,
   vga_if.out                     vga_out
);

   localparam int L  = ROM_LAT + 2;
   localparam int HD = ROM_LAT + 1;

   upd_state_t   state_q, state_d;
   sprite_attr_t active_q, active_d;
   sprite_attr_t shadow_q, shadow_d;
   logic         vblnk_q;
   logic         frameStart;
   logic         updFire;

   assign frameStart = vga_in.vblnk && !vblnk_q;
   assign updFire    = upd_valid && upd_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= UPD_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         UPD_IDLE:    if (updFire)    state_d = UPD_PENDING;
         UPD_PENDING: if (frameStart) state_d = UPD_IDLE;
         default:                     state_d = UPD_IDLE;
      endcase
   end

   always_comb begin
      upd_ready = (state_q == UPD_IDLE);
   end

   // Active attributes only move at frame start so no frame shows a torn sprite.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (updFire) begin
         shadow_d = '{x: upd_x, y: upd_y, hflip: upd_hflip, vflip: upd_vflip, en: upd_en};
      end
      if (state_q == UPD_PENDING && frameStart) begin
         active_d = shadow_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
         active_q <= '0;
         vblnk_q  <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         vblnk_q  <= vga_in.vblnk;
      end
   end

   logic [12:0]     hcExt, vcExt, xExt, yExt;
   logic            hit;
   logic [AX_W-1:0] dx, col;
   logic [AY_W-1:0] dy, row;

   // 13-bit compares keep a sprite parked near x=4095 from wrapping onto the screen.
   always_comb begin
      hcExt = {2'b00, vga_in.hcount};
      vcExt = {2'b00, vga_in.vcount};
      xExt  = {1'b0, active_q.x};
      yExt  = {1'b0, active_q.y};
      hit   = active_q.en
              && (hcExt >= xExt) && (hcExt < xExt + 13'(W))
              && (vcExt >= yExt) && (vcExt < yExt + 13'(H));
      dx    = AX_W'(hcExt - xExt);
      dy    = AY_W'(vcExt - yExt);
      col   = active_q.hflip ? AX_W'(W - 1) - dx : dx;
      row   = active_q.vflip ? AY_W'(H - 1) - dy : dy;
   end

   logic [AY_W+AX_W-1:0] pixelAddr_q;
   logic [HD-1:0]        hitPipe_q;
   logic [VGA_RGB_W-1:0] rgbPipe_q [HD];
   logic [VGA_RGB_W-1:0] rgbOut_q;
   logic                 hitD;
   logic [VGA_RGB_W-1:0] rgbD;
   logic                 drawSprite;

   always_ff @(posedge clk) begin
      if (rst) begin
         pixelAddr_q <= '0;
      end else begin
         pixelAddr_q <= hit ? {row, col} : '0;
      end
   end

   assign pixel_addr = pixelAddr_q;

   // Hit flag and background colour wait here for the ROM data to arrive.
   always_ff @(posedge clk) begin
      if (rst) begin
         hitPipe_q <= '0;
         for (int i = 0; i < HD; i++) begin
            rgbPipe_q[i] <= '0;
         end
      end else begin
         hitPipe_q[0] <= hit;
         rgbPipe_q[0] <= vga_in.rgb;
         for (int i = 1; i < HD; i++) begin
            hitPipe_q[i] <= hitPipe_q[i-1];
            rgbPipe_q[i] <= rgbPipe_q[i-1];
         end
      end
   end

   assign hitD = hitPipe_q[HD-1];
   assign rgbD = rgbPipe_q[HD-1];

`ifdef DRAW_SPRITE_CTL_TRANSP_EN
   assign drawSprite = hitD && (rgb_pixel != TRANSP_KEY);
`else
   assign drawSprite = hitD;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rgbOut_q <= '0;
      end else begin
         rgbOut_q <= drawSprite ? rgb_pixel : rgbD;
      end
   end

   assign vga_out.rgb = rgbOut_q;

   vga_delay #(
      .DEPTH(L)
   ) u_vga_delay (
      .clk      (clk),
      .rst      (rst),
      .hcount_i (vga_in.hcount),
      .vcount_i (vga_in.vcount),
      .hsync_i  (vga_in.hsync),
      .vsync_i  (vga_in.vsync),
      .hblnk_i  (vga_in.hblnk),
      .vblnk_i  (vga_in.vblnk),
      .hcount_o (vga_out.hcount),
      .vcount_o (vga_out.vcount),
      .hsync_o  (vga_out.hsync),
      .vsync_o  (vga_out.vsync),
      .hblnk_o  (vga_out.hblnk),
      .vblnk_o  (vga_out.vblnk)
   );

endmodule

// File: doc/draw_sprite_ctl.md
Name: draw_sprite_ctl

Overview:
- Parametrised successor to the fixed-rectangle sprite drawer for the VGA pixel pipeline.
- Overlays one W×H bitmap, fetched from an external image ROM, onto the incoming vga_if stream.
- New versus the previous drawer:
  - ROM read latency is a parameter.
  - Horizontal/vertical mirroring.
  - Enable input.
  - Position/attribute updates through a valid/ready handshake, committed only at frame start so a frame never shows a half-moved sprite.
- Sits between the background/previous layer and the next layer or the VGA output.

Parameters:
- W, 48, sprite width in pixels (1..2^AX_W)
- H, 64, sprite height in pixels (1..2^AY_W)
- AX_W, 6, column bits of pixel_addr
- AY_W, 6, row bits of pixel_addr
- ROM_LAT, 1, clock edges from a pixel_addr change to the matching rgb_pixel (0..4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- upd_valid  in  1  new attribute set offered
- upd_ready  out  1  block can accept an attribute set
- upd_x  in  12  new left edge
- upd_y  in  12  new top edge
- upd_hflip  in  1  mirror columns
- upd_vflip  in  1  mirror rows
- upd_en  in  1  sprite visible
- rgb_pixel  in  12  ROM data
- pixel_addr  out  AY_W+AX_W  ROM address, {row, col}
- vga_in  vga_if.in  -  hcount/vcount 11b, hsync, vsync, hblnk, vblnk, rgb 12b
- vga_out  vga_if.out  -  same fields, delayed

Behaviour:
- Clock and reset: clk, synchronous active-high rst.
- Reset values:
  - All vga_out fields 0; pixel_addr 0; upd_ready 1.
  - Active and shadow attributes: x=0, y=0, flips=0, en=0.
  - FSM in IDLE.
- FSM:
  - IDLE: upd_ready=1. A handshake (upd_valid && upd_ready) latches upd_* into the shadow registers and moves to PENDING.
  - PENDING: upd_ready=0. On the first cycle where vga_in.vblnk=1 and its previous sampled value was 0 (frame start), shadow is copied to active and the FSM returns to IDLE.
  - Frame-start check uses a 1-cycle registered copy of vblnk. The copy resets to 0.
  - An update accepted while vblnk is already high waits for the next rising edge of vblnk.
  - Active attributes change only in the PENDING→IDLE transition; mid-frame updates never alter the frame in progress.
  - Reset mid-PENDING discards the shadow.
- Hit test, stage 0, on vga_in:
  - hit = en && hcount>=x && hcount<x+W && vcount>=y && vcount<y+H.
  - Sums use 13-bit arithmetic, so x near 4095 never wraps to a false hit.
  - dx = hcount−x and dy = vcount−y, truncated to AX_W/AY_W.
  - col = hflip ? W−1−dx : dx; row = vflip ? H−1−dy : dy.
- pixel_addr:
  - Registered {row, col} when hit, else 0.
  - Valid 1 cycle after the vga_in sample.
- Output path:
  - vga_out.rgb = hit_d ? rgb_pixel : rgb_d. hit_d and rgb_d are hit and vga_in.rgb delayed to align with rgb_pixel.
  - Total latency L = ROM_LAT+2 cycles for every vga_out field. Timing fields are a pure delay line of depth L.
  - Identical latency with or without a hit.
- Boundaries:
  - Sprite partially off-screen right/bottom: visible part drawn, no wrap.
  - x=0, y=0: drawn from hcount 0.
  - en=0: rgb passes through, pixel_addr stays 0.

Optional Feature:
- Macro: DRAW_SPRITE_CTL_TRANSP_EN.
- Defined:
  - Adds parameter TRANSP_KEY (default 12'hF0F).
  - A hit whose rgb_pixel equals TRANSP_KEY outputs the delayed vga_in.rgb instead.
- Undefined: every hit pixel is drawn as fetched; no TRANSP_KEY parameter.

Decomposition:
- Shared package draw_pkg:
  - sprite_attr_t struct {x[11:0], y[11:0], hflip, vflip, en}.
  - VGA_RGB_W=12, VGA_CNT_W=11.
- Sub-module vga_delay:
  - Parameter DEPTH.
  - Registered delay of all timing fields (hcount, vcount, hsync, vsync, hblnk, vblnk), reset to 0.
  - Instantiated with DEPTH=L.

Test Plan:
1. Update x=100, y=50, en=1 accepted mid-frame → pixels unchanged until the next vblnk rise; the following frame:
   - hcount=100, vcount=50 → pixel_addr=0.
   - hcount=147, vcount=113 → pixel_addr={63,47}.
   - hcount=148 → background rgb.
2. ROM model with ROM_LAT=1 and 3 → vga_out delayed exactly 3 and 5 cycles versus vga_in on all fields; sprite rgb aligned to hcount.
3. hflip=1, vflip=1 at x=0, y=0 → hcount=0, vcount=0 gives pixel_addr={63,47}.
4. x=4090, W=48 → no hit anywhere on a 1024-wide frame; en=0 → pass-through.
5. Second upd_valid while PENDING → upd_ready=0 and no accept; rst in PENDING → active stays at reset values, upd_ready=1.
6. With DRAW_SPRITE_CTL_TRANSP_EN, ROM returns 12'hF0F → background shown; returns 12'h0F0 → 12'h0F0 shown.
